shape_pixel_streamer: RTL
=========================

// Module: shape_pixel_streamer
// PURPOSE
//  Consumer side of the shape bitmap interface. Snapshots a HEIGHT x WIDTH shape
//  bitmap (array of rows) on request and streams it pixel-by-pixel in raster order
//  over a valid/ready handshake. It feeds the display driver's cell renderer.
//  Bit value 1 = background, 0 = ink. Pixel bits pass through unmodified.
// PARAMETERS
//  WIDTH   25  pixels per bitmap row (bit WIDTH-1 = leftmost column, x=0)
//  HEIGHT  25  rows per bitmap (array index 0 = top row, y=0)
//  CW      $clog2(2*WIDTH)   coordinate width (derived localparam; 6 at defaults)
// PORTS
//  clk        in   1           system clock, rising edge
//  reset_n    in   1           async active-low reset
//  shape_in   in   [WIDTH-1:0] [0:HEIGHT-1]  source bitmap (e.g. shape ROM oshapes)
//  start      in   1           request a frame; sampled only in IDLE
//  busy       out  1           high from accepted start until DONE exits
//  pix_valid  out  1           pixel beat valid
//  pix_ready  in   1           downstream accepts beat when pix_valid&&pix_ready
//  pix_data   out  1           pixel bit
//  pix_x      out  CW          column of current beat
//  pix_y      out  CW          row of current beat
//  pix_eol    out  1           current beat is last in its row
//  pix_last   out  1           current beat is last of frame
//  done       out  1           one-cycle pulse after last beat accepted
// BEHAVIOUR
//  Reset (async, reset_n=0): state=IDLE. All outputs 0. Frame buffer cleared to all 1s.
//  FSM IDLE -> STREAM -> DONE -> IDLE.
//   IDLE: start=1 at edge N -> copy shape_in to internal frame buffer; x=y=0; go STREAM.
//     At N+1: pix_valid=1 with pixel (0,0); busy=1.
//   STREAM: pix_valid held 1. pix_data/x/y/eol/last stay stable until handshake.
//     On a handshake, advance x. At x=XMAX, wrap x to 0 and increment y.
//     The next beat is valid on the following cycle. There are no bubbles under ready=1.
//     Handshake on the beat with pix_last=1 -> DONE. pix_valid=0 next cycle.
//   DONE: done=1, busy=1 for exactly one cycle -> IDLE.
//   In IDLE, busy=0 and pix_valid=0. pix_x, pix_y and pix_data hold their last values.
//  start while busy: ignored. It is not queued.
//  A start that coincides with the DONE cycle is also ignored.
//  shape_in changes after snapshot: no effect on the frame in flight.
//  pix_ready while pix_valid=0: ignored.
//  pix_eol = (x==XMAX). pix_last = (x==XMAX)&&(y==YMAX).
//  Unscaled: XMAX=WIDTH-1, YMAX=HEIGHT-1.
//   pix_data = frame[y][WIDTH-1-x].
//   Beat count per frame = WIDTH*HEIGHT (625 at defaults).
//  Throughput: 1 beat/cycle under continuous ready.
//   Frame latency = start edge + 1 + beats + 1 (DONE).
//  reset_n asserted mid-frame: immediate return to IDLE with all outputs 0.
//   After release, the bench must issue a new start.
// CONFIGURATION
//  SHAPE_SCALE2_EN defined:
//   Output is a 2x nearest-neighbour upscale.
//   XMAX=2*WIDTH-1, YMAX=2*HEIGHT-1. pix_data = frame[y>>1][WIDTH-1-(x>>1)].
//   Beat count per frame = 4*WIDTH*HEIGHT (2500).
//  SHAPE_SCALE2_EN undefined: unscaled behaviour above.
//  Port widths are identical in both builds.
// TESTING
//  1. All-1 bitmap except row 3 bit 23=0; start; ready=1 -> 625 beats.
//     Only (x=1,y=3) has data=0. eol on x=24. last on (24,24).
//     done pulses 1 cycle after beat 625.
//  2. Ready toggling 1,0,0,1 pattern -> no beat dropped or duplicated.
//     Data/x/y stable while valid&&!ready. Sequence matches test 1.
//  3. start pulses at beats 10 and 624, and in the DONE cycle -> no restart.
//     Exactly 625 beats. Next start from IDLE yields a fresh frame.
//  4. Change shape_in to all-0 one cycle after start -> streamed frame equals
//     the bitmap at the start edge.
//  5. Assert reset_n=0 at beat 300 -> same cycle: pix_valid=0, busy=0, done=0.
//     After release plus start -> frame restarts at (0,0).
//  6. SHAPE_SCALE2_EN with the test-1 bitmap -> 2500 beats.
//     data=0 only at (2,6), (3,6), (2,7), (3,7). last on (49,49).

Source files
------------

// File: rtl/shape_pixel_streamer.sv
// -----------------------------------------------------------------------------
// shape_pixel_streamer
//
// Purpose:
//   Snapshots a HEIGHT x WIDTH shape bitmap on request and streams it
//   pixel-by-pixel in raster order (left to right, top to bottom) over a
//   valid/ready handshake. Bit value 1 = background, 0 = ink; pixel bits are
//   passed through unmodified.
//
// Build option:
//   SHAPE_SCALE2_EN - when defined, the frame is streamed as a 2x
//   nearest-neighbour upscale (2*WIDTH x 2*HEIGHT beats). Port widths are the
//   same in both builds.
//
// Ports:
//   clk        in   system clock, rising edge
//   reset_n    in   asynchronous active-low reset
//   shape_in   in   [WIDTH-1:0] x [0:HEIGHT-1] source bitmap (row 0 = top,
//                   bit WIDTH-1 = leftmost column)
//   start      in   frame request, only honoured while idle
//   busy       out  high from the accepted start until the done cycle ends
//   pix_valid  out  pixel beat valid
//   pix_ready  in   downstream accepts the beat when pix_valid && pix_ready
//   pix_data   out  pixel bit
//   pix_x      out  column of the current beat
//   pix_y      out  row of the current beat
//   pix_eol    out  current beat is the last of its row
//   pix_last   out  current beat is the last of the frame
//   done       out  one-cycle pulse after the last beat is accepted
// -----------------------------------------------------------------------------
module shape_pixel_streamer #(
  parameter  int WIDTH  = 25,
  parameter  int HEIGHT = 25,
  localparam int CW     = $clog2(2 * WIDTH)
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [WIDTH-1:0] shape_in [0:HEIGHT-1],
  input  logic             start,
  output logic             busy,
  output logic             pix_valid,
  input  logic             pix_ready,
  output logic             pix_data,
  output logic [CW-1:0]    pix_x,
  output logic [CW-1:0]    pix_y,
  output logic             pix_eol,
  output logic             pix_last,
  output logic             done
);

`ifdef SHAPE_SCALE2_EN
  localparam int SC = 1;  // output coordinate -> source coordinate shift
`else
  localparam int SC = 0;
`endif

  localparam logic [CW-1:0] XMAX = CW'((WIDTH << SC) - 1);
  localparam logic [CW-1:0] YMAX = CW'((HEIGHT << SC) - 1);
  localparam int RW = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
  localparam int XW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_STREAM,
    ST_DONE
  } state_t;

  state_t            r_state;
  state_t            w_state_next;

  logic [WIDTH-1:0]  r_frame [0:HEIGHT-1];
  logic [CW-1:0]     r_x;
  logic [CW-1:0]     r_y;
  logic              r_data;

  logic              w_accept;
  logic              w_hs;
  logic              w_last;
  logic              w_advance;
  logic [CW-1:0]     w_nx;
  logic [CW-1:0]     w_ny;
  logic [RW-1:0]     w_row;
  logic [XW-1:0]     w_col;

  // ---------------------------------------------------------------------------
  // Control decode
  // ---------------------------------------------------------------------------
  assign w_accept  = (r_state == ST_IDLE) && start;
  assign w_hs      = (r_state == ST_STREAM) && pix_ready;
  assign w_last    = (r_x == XMAX) && (r_y == YMAX);
  // The final beat does not advance the coordinates, so x/y keep showing the
  // last beat while the block sits in DONE and IDLE.
  assign w_advance = w_hs && !w_last;

  // Raster successor of the current beat.
  assign w_nx = (r_x == XMAX) ? '0 : r_x + 1'b1;
  assign w_ny = (r_x == XMAX) ? r_y + 1'b1 : r_y;

  // Source pixel of the successor beat; columns are mirrored because bit
  // WIDTH-1 holds the leftmost pixel.
  assign w_row = RW'(w_ny >> SC);
  assign w_col = XW'(CW'(WIDTH - 1) - (w_nx >> SC));

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // ---------------------------------------------------------------------------
  // FSM: next state
  // ---------------------------------------------------------------------------
  always_comb begin
    w_state_next = r_state;
    case (r_state)
      ST_IDLE: begin
        if (start) begin
          w_state_next = ST_STREAM;
        end
      end
      ST_STREAM: begin
        if (pix_ready && w_last) begin
          w_state_next = ST_DONE;
        end
      end
      ST_DONE: begin
        // start is deliberately not sampled here.
        w_state_next = ST_IDLE;
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------------
  // Frame buffer: one register row per bitmap row, loaded only when a start
  // is accepted so later changes on shape_in do not reach the frame in flight.
  // ---------------------------------------------------------------------------
  generate
    for (genvar gi = 0; gi < HEIGHT; gi++) begin : g_row
      always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
          r_frame[gi] <= '1;
        end else if (w_accept) begin
          r_frame[gi] <= shape_in[gi];
        end
      end
    end
  endgenerate

  // ---------------------------------------------------------------------------
  // Beat registers. The pixel bit is fetched one step ahead so the beat is
  // fully registered; the very first pixel comes straight from shape_in
  // because the frame buffer is loaded on the same edge.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_x    <= '0;
      r_y    <= '0;
      r_data <= 1'b0;
    end else if (w_accept) begin
      r_x    <= '0;
      r_y    <= '0;
      r_data <= shape_in[0][WIDTH-1];
    end else if (w_advance) begin
      r_x    <= w_nx;
      r_y    <= w_ny;
      r_data <= r_frame[w_row][w_col];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign busy      = (r_state != ST_IDLE);
  assign pix_valid = (r_state == ST_STREAM);
  assign done      = (r_state == ST_DONE);
  assign pix_data  = r_data;
  assign pix_x     = r_x;
  assign pix_y     = r_y;
  // Flags are qualified with valid so the held coordinates in IDLE/DONE do
  // not show a stale end-of-row / end-of-frame marker.
  assign pix_eol   = pix_valid && (r_x == XMAX);
  assign pix_last  = pix_valid && w_last;

endmodule
